// File: rtl/gaussian_filter_accel_pkg.sv
// Shared constants and width helpers for the Gaussian filter tap accumulator.
// Imported by the accumulator top and its rounding/saturation stage.
package gaussian_filter_accel_pkg;

   localparam int NTAPS_DEF = 9;
   localparam int SHIFT_DEF = 16;
   localparam int OUT_W_DEF = 8;
   localparam int PROD_W    = 32;

   // Wide enough that NTAPS full-scale products can never wrap.
   function automatic int acc_w(input int ntaps);
      return PROD_W + $clog2(ntaps);
   endfunction

   // Tap counter width; at least one bit even for a single tap.
   function automatic int cnt_w(input int ntaps);
      return (ntaps > 1) ? $clog2(ntaps) : 1;
   endfunction

endpackage

// File: rtl/gaussian_filter_accel_round_sat.sv
// Combinational scale-down of a tap sum to an output pixel with clamping.
// Define GAUSSIAN_ACCUM_ROUND_EN for round-half-up; otherwise truncate.
module gaussian_filter_accel_round_sat
   import gaussian_filter_accel_pkg::*;
#(
   parameter int ACC_W = 36,
   parameter int SHIFT = SHIFT_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [ACC_W-1:0] sum,
   output logic [OUT_W-1:0] pix,
   output logic             sat
);

   // One spare bit so the rounding bias cannot overflow the sum.
   localparam int EXT_W  = ACC_W + 1;
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic [EXT_W-1:0] PIX_MAX =
      {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

`ifdef GAUSSIAN_ACCUM_ROUND_EN
   localparam logic [EXT_W-1:0] RND =
      (SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
`else
   localparam logic [EXT_W-1:0] RND = '0;
`endif

   logic [EXT_W-1:0] biased;
   logic [EXT_W-1:0] scaled;

   // Bias, drop the coefficient fraction, then clamp to the pixel range.
   always_comb begin
      biased = {1'b0, sum} + RND;
      scaled = biased >> SHIFT;
      sat    = (scaled > PIX_MAX);
      pix    = sat ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
   end

endmodule

// File: rtl/gaussian_filter_accel_tap_accum.sv
// Sums NTAPS kernel-tap products into one output pixel with backpressure.
// Rounding mode is selected by GAUSSIAN_ACCUM_ROUND_EN (default truncates).
module gaussian_filter_accel_tap_accum
   import gaussian_filter_accel_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod,
   input  logic              acc_clr,
   output logic              ce_out,
   output logic              pix_valid,
   output logic [OUT_W-1:0]  pix_data,
   input  logic              pix_ready,
   output logic              sat
);

   localparam int ACC_W = acc_w(NTAPS);
   localparam int CNT_W = cnt_w(NTAPS);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(NTAPS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_eff;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum_next;
   logic             accept;
   logic             last;
   logic             load;
   logic [OUT_W-1:0] rs_pix;
   logic             rs_sat;

   // Stall the multiplier only while a pixel is held unaccepted.
   // A held pixel therefore blocks any new load, keeping pix_data stable.
   assign ce_out   = ~(pix_valid & ~pix_ready);
   assign accept   = prod_valid & ce_out;
   assign cnt_eff  = acc_clr ? '0 : cnt;
   assign prod_ext = ACC_W'(prod);
   assign last     = (cnt_eff == LAST);
   assign load     = accept & last;

   // Tap 0 (or a tap arriving with a clear) starts a fresh sum.
   always_comb begin
      sum_next = prod_ext;
      if (cnt_eff != '0) begin
         sum_next = acc + prod_ext;
      end
   end

   gaussian_filter_accel_round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .sum (sum_next),
      .pix (rs_pix),
      .sat (rs_sat)
   );

   // Tap counter and partial sum; cleared at the end of each pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         if (last) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt_eff + CNT_W'(1);
            acc <= sum_next;
         end
      end else if (acc_clr) begin
         cnt <= '0;
         acc <= '0;
      end
   end

   // Output pixel register; a load replaces a pixel consumed that cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_valid <= 1'b0;
         pix_data  <= '0;
         sat       <= 1'b0;
      end else begin
         sat <= load & rs_sat;
         if (load) begin
            pix_valid <= 1'b1;
            pix_data  <= rs_pix;
         end else if (pix_valid & pix_ready) begin
            pix_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gaussian_filter_accel_tap_accum.sv
// Scoreboard bench for the Gaussian tap accumulator.
// Expected pixels are queued by stimulus and checked by a monitor.
module tb_gaussian_filter_accel_tap_accum;

   logic        clk = 1'b0;
   logic        reset;
   logic        prod_valid;
   logic [31:0] prod;
   logic        acc_clr;
   logic        ce_out;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_ready;
   logic        sat;

   always #5 clk = ~clk;

   gaussian_filter_accel_tap_accum dut (
      .clk        (clk),
      .reset      (reset),
      .prod_valid (prod_valid),
      .prod       (prod),
      .acc_clr    (acc_clr),
      .ce_out     (ce_out),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .sat        (sat)
   );

   typedef struct packed {
      logic [7:0] pix;
      logic       sat;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

`ifdef GAUSSIAN_ACCUM_ROUND_EN
   localparam logic [7:0] EXP_HALF = 8'd2;
`else
   localparam logic [7:0] EXP_HALF = 8'd1;
`endif

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout/unexpected expected event", name);
   endtask

   // Monitor: pops and compares on every consumed pixel.
   logic prev_valid = 1'b0;
   logic prev_cons  = 1'b0;
   always @(negedge clk) begin
      logic fresh;
      exp_t e;
      if (reset) begin
         prev_valid = 1'b0;
         prev_cons  = 1'b0;
      end else begin
         fresh = pix_valid && (!prev_valid || prev_cons);
         if (pix_valid) begin
            if (fresh) begin
               if (q.size() == 0) fail_now("unexpected_pixel");
               else check("sat_pulse", 32'(sat), 32'(q[0].sat));
            end else begin
               check("sat_stray", 32'(sat), 32'd0);
            end
            if (pix_ready && q.size() > 0) begin
               e = q.pop_front();
               check("pix_data", 32'(pix_data), 32'(e.pix));
            end
         end else begin
            check("sat_idle", 32'(sat), 32'd0);
         end
         prev_valid = pix_valid;
         prev_cons  = pix_valid && pix_ready;
      end
   end

   // Offer one product until accepted; drive at posedge+1.
   task automatic put(input logic [31:0] p,
                      input logic clr,
                      output int stalls);
      logic got;
      got        = 1'b0;
      stalls     = 0;
      prod_valid = 1'b1;
      prod       = p;
      acc_clr    = clr;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = ce_out;
         @(posedge clk);
         #1;
         if (!got) stalls++;
      end
      if (!got) fail_now("put_timeout");
      prod_valid = 1'b0;
      acc_clr    = 1'b0;
   endtask

   // Nine taps: p0 first, then eight of prest; queue the expectation.
   task automatic burst(input logic [31:0] p0,
                        input logic [31:0] prest,
                        input logic clr0,
                        input logic [7:0] e_pix,
                        input logic e_sat,
                        output int stalls);
      int s;
      exp_t e;
      put(p0, clr0, s);
      stalls = s;
      for (int i = 0; i < 8; i++) begin
         put(prest, 1'b0, s);
         stalls += s;
      end
      e.pix = e_pix;
      e.sat = e_sat;
      q.push_back(e);
   endtask

   task automatic drain();
      pix_ready = 1'b1;
      for (int i = 0; i < 50 && (q.size() != 0 || pix_valid); i++)
         @(posedge clk);
      #1;
      if (q.size() != 0) fail_now("drain");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      reset      = 1'b1;
      prod_valid = 1'b0;
      prod       = '0;
      acc_clr    = 1'b0;
      pix_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_data", 32'(pix_data), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      check("rst_ce", 32'(ce_out), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Unit coefficients sum to 9.
      burst(32'h0001_0000, 32'h0001_0000, 1'b0, 8'd9, 1'b0, s);
      drain();

      // 1.5 rounds up or truncates.
      burst(32'h0001_8000, 32'h0, 1'b0, EXP_HALF, 1'b0, s);
      drain();

      // Full-scale products saturate without wrapping.
      burst(32'hFFFE_0001, 32'hFFFE_0001, 1'b0, 8'd255, 1'b1, s);
      drain();

      // Backpressure: hold the pixel, ignore products, then resume.
      pix_ready = 1'b0;
      burst(32'h0002_0000, 32'h0002_0000, 1'b0, 8'd18, 1'b0, s);
      prod_valid = 1'b1;
      prod       = 32'h0003_0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_ce", 32'(ce_out), 32'd0);
         check("stall_hold", 32'(pix_data), 32'd18);
         check("stall_valid", 32'(pix_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      pix_ready = 1'b1;
      burst(32'h0003_0000, 32'h0003_0000, 1'b0, 8'd27, 1'b0, s);
      drain();

      // Reset in the middle of a burst discards the partial sum.
      for (int i = 0; i < 4; i++) put(32'h0007_0000, 1'b0, s);
      #2;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_valid", 32'(pix_valid), 32'd0);
      check("midrst_ce", 32'(ce_out), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      burst(32'h0001_0000, 32'h0001_0000, 1'b0, 8'd9, 1'b0, s);
      drain();

      // Clear arriving with a product makes that product tap 0.
      for (int i = 0; i < 4; i++) put(32'h0007_0000, 1'b0, s);
      burst(32'h0001_0000, 32'h0001_0000, 1'b1, 8'd9, 1'b0, s);
      drain();

      // Back-to-back bursts with no stalls, plus clamp boundaries.
      burst(32'h0002_0000, 32'h0002_0000, 1'b0, 8'd18, 1'b0, s);
      check("b2b_stall_a", 32'(s), 32'd0);
      burst(32'h00FF_0000, 32'h0001_0000, 1'b0, 8'd255, 1'b1, s);
      check("b2b_stall_b", 32'(s), 32'd0);
      burst(32'h00FF_0000, 32'h0, 1'b0, 8'd255, 1'b0, s);
      check("b2b_stall_c", 32'(s), 32'd0);
      burst(32'h0100_0000, 32'h0, 1'b0, 8'd255, 1'b1, s);
      check("b2b_stall_d", 32'(s), 32'd0);
      drain();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gaussian_filter_accel_tap_accum.md
GAUSSIAN_FILTER_ACCEL_TAP_ACCUM -- requirements
Module: gaussian_filter_accel_tap_accum

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous, active-high.
REQ-002 Parameter NTAPS, default 9, SHALL set the number of kernel-tap products per output pixel (3x3 kernel).
REQ-003 Parameter SHIFT, default 16, SHALL set the coefficient fraction bits to remove (Q0.16 coefficients).
REQ-004 Parameter OUT_W, default 8, SHALL set the output pixel width.
REQ-005 Port clk, in, 1: clock, rising edge.
REQ-006 Port reset, in, 1: asynchronous active-high reset.
REQ-007 Port prod_valid, in, 1: prod carries a valid tap product.
REQ-008 Port prod, in, 32: unsigned 16x16 tap product from the upstream multiplier.
REQ-009 Port acc_clr, in, 1: synchronous clear of a partial accumulation.
REQ-010 Port ce_out, out, 1: clock enable to the upstream multiplier; low means stall.
REQ-011 Port pix_valid, out, 1: pix_data is valid.
REQ-012 Port pix_data, out, OUT_W: filtered pixel.
REQ-013 Port pix_ready, in, 1: downstream accepts pix_data.
REQ-014 Port sat, out, 1: one-cycle pulse when a loaded pixel was saturated.

Function
REQ-015 ce_out SHALL equal NOT(pix_valid AND NOT pix_ready), combinationally.
REQ-016 A product SHALL be accepted only when prod_valid AND ce_out; prod is ignored otherwise.
REQ-017 Accumulator width SHALL be 32+clog2(NTAPS) bits and SHALL never wrap.
REQ-018 Tap counter cnt SHALL run 0..NTAPS-1; first accepted product loads acc, later ones add to it.
REQ-019 On the accepted product with cnt==NTAPS-1, the sum SHALL be shifted right by SHIFT, saturated to 2^OUT_W-1, and loaded into pix_data with pix_valid=1 on the next edge; cnt SHALL return to 0.
REQ-020 Latency SHALL be 1 cycle from last-tap acceptance to pix_valid.
REQ-021 pix_data SHALL stay stable while pix_valid AND NOT pix_ready.
REQ-022 A pixel SHALL be consumed on pix_valid AND pix_ready; if it coincides with a new load, the new pixel SHALL replace it with pix_valid held at 1.
REQ-023 On a consume with no load, pix_valid SHALL drop to 0 on the next edge.
REQ-024 sat SHALL pulse high for exactly the cycle after a saturated load.
REQ-025 acc_clr SHALL set cnt to 0 and discard the partial sum; a product accepted in the same cycle SHALL be treated as tap 0.
REQ-026 acc_clr SHALL NOT affect pix_valid or pix_data.

Reset
REQ-027 Reset SHALL drive cnt=0, acc=0, pix_valid=0, pix_data=0, sat=0, and ce_out to 1.
REQ-028 Reset mid-accumulation SHALL discard the partial sum; the next NTAPS accepted products SHALL form a complete pixel.

Configuration
REQ-029 With GAUSSIAN_ACCUM_ROUND_EN defined, 2^(SHIFT-1) SHALL be added before the shift (round half up).
REQ-030 Without GAUSSIAN_ACCUM_ROUND_EN, the shift SHALL truncate.

Structure
REQ-031 Package gaussian_filter_accel_pkg SHALL hold the defaults for NTAPS, SHIFT and OUT_W, the product width constant (32), and the accumulator-width function.
REQ-032 Rounding and saturation SHALL be a combinational sub-module, gaussian_filter_accel_round_sat.

Verification
REQ-033 Nine products of 0x00010000, pix_ready=1 -> pix_data=9, pix_valid for 1 cycle, sat=0.
REQ-034 Tap sum 0x00018000 (prod 0x00018000, then eight zeros) -> pix_data=2 with ROUND_EN, 1 without.
REQ-035 Nine products of 0xFFFE0001 -> pix_data=255, sat pulses once, no accumulator wrap.
REQ-036 pix_ready=0 after a pixel load -> ce_out=0, pix_data held, products with prod_valid=1 ignored; pix_ready=1 -> ce_out=1 and the burst resumes with no lost taps.
REQ-037 Reset, or acc_clr, after 4 accepted products, then nine 0x00010000 -> exactly one pixel of value 9.
REQ-038 Back-to-back bursts with pix_ready=1 -> one pixel every 9 accepted products, ce_out constantly 1.
